// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   DMEM_BASE / DMEM_WORDS : default data-memory window (0x400, 256 words)
//   gnt_e                  : which master owns the memory port this cycle
//   addr_legal()           : window + word-alignment check
package dmem_arb_pkg;

    localparam logic [31:0] DMEM_BASE  = 32'h0000_0400;
    localparam int          DMEM_WORDS = 256;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_AUX  = 2'd2
    } gnt_e;

    // The window end is computed in 33 bits so a window touching the top of the
    // address space cannot wrap and admit addresses such as 32'hFFFF_FFFC.
    function automatic logic addr_legal(input logic [31:0] a,
                                        input logic [31:0] base,
                                        input int          words);
        logic [32:0] a33;
        logic [32:0] lo;
        logic [32:0] hi;
        a33 = {1'b0, a};
        lo  = {1'b0, base};
        hi  = lo + (33'(words) << 2);
        return (a[1:0] == 2'b00) && (a33 >= lo) && (a33 < hi);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (MEM stage, aux loader/debug), the
// single-port data memory and the arbiter.
//   cpu_*      : MEM-stage load/store request and same-cycle response
//   aux_*      : valid/ready request channel plus registered response
//   err_*      : sticky fault log
//   MemRead/MemWrite/addr/write_data/read_data : data-memory port
// Modports: master = requesters + memory side, slave = arbiter.
interface dmem_arbiter_if;

    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_fault;

    logic        aux_valid;
    logic        aux_we;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_ready;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;
    logic        aux_err;

    logic [31:0] err_addr;
    logic        err_flag;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output aux_valid, aux_we, aux_addr, aux_wdata,
        output read_data,
        input  cpu_rdata, cpu_stall, cpu_fault,
        input  aux_ready, aux_rvalid, aux_rdata, aux_err,
        input  err_addr, err_flag,
        input  MemRead, MemWrite, addr, write_data
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  aux_valid, aux_we, aux_addr, aux_wdata,
        input  read_data,
        output cpu_rdata, cpu_stall, cpu_fault,
        output aux_ready, aux_rvalid, aux_rdata, aux_err,
        output err_addr, err_flag,
        output MemRead, MemWrite, addr, write_data
    );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Aux starvation counter. Counts consecutive cycles in which the aux master
// is waiting without being accepted and raises force_aux once the count has
// reached STARVE_LIMIT, so the aux master never waits more than that.
//   clk, reset : clock, synchronous active-high reset
//   aux_valid  : aux request pending
//   aux_ready  : aux request accepted this cycle
//   force_aux  : aux must be granted this cycle
module dmem_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic aux_valid,
    input  logic aux_ready,
    output logic force_aux
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!aux_valid || aux_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign force_aux = aux_valid && (wait_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the MEM
// stage (priority, zero latency) and an aux master (valid/ready, one-cycle
// registered response). Illegal (out-of-window or misaligned) accesses never
// strobe the memory; they are reported and the first one is logged.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arbiter_if.slave (CPU, aux, fault log, memory port)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DMEM_BASE,
    parameter int          WORDS        = DMEM_WORDS,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    gnt_e        gnt;
    logic        cpu_act;
    logic        force_aux;
    logic        sel_rd;
    logic        sel_wr;
    logic        sel_legal;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic        rsp_vld_p1;
    logic        rsp_err_p1;
    logic [31:0] rsp_data_p1;
    logic        err_flag_q;
    logic [31:0] err_addr_q;

    assign cpu_act = bus.cpu_rd | bus.cpu_wr;

    dmem_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .aux_valid(bus.aux_valid),
        .aux_ready(bus.aux_ready),
        .force_aux(force_aux)
    );

    // A starved aux master overrides the CPU; otherwise CPU has priority.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (force_aux) begin
                gnt = GNT_AUX;
            end else if (cpu_act) begin
                gnt = GNT_CPU;
            end else if (bus.aux_valid) begin
                gnt = GNT_AUX;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        case (gnt)
            GNT_CPU: begin
                sel_addr  = bus.cpu_addr;
                sel_wdata = bus.cpu_wdata;
                sel_rd    = bus.cpu_rd;
                sel_wr    = bus.cpu_wr;
            end
            GNT_AUX: begin
                sel_addr  = bus.aux_addr;
                sel_wdata = bus.aux_wdata;
                sel_rd    = ~bus.aux_we;
                sel_wr    = bus.aux_we;
            end
            default: begin
                sel_addr  = '0;
                sel_wdata = '0;
                sel_rd    = 1'b0;
                sel_wr    = 1'b0;
            end
        endcase
    end

    assign sel_legal = addr_legal(sel_addr, BASE_ADDR, WORDS);

    assign bus.addr       = sel_addr;
    assign bus.write_data = sel_wdata;
    assign bus.MemRead    = sel_rd & sel_legal;
    assign bus.MemWrite   = sel_wr & sel_legal;

    assign bus.aux_ready  = (gnt == GNT_AUX);
    assign bus.cpu_stall  = (gnt == GNT_AUX) & cpu_act;
    assign bus.cpu_fault  = (gnt == GNT_CPU) & ~sel_legal;
    assign bus.cpu_rdata  = ((gnt == GNT_CPU) & bus.cpu_rd & sel_legal) ? bus.read_data : '0;

    // ---- p1: aux response register ----
    // Legal writes are silent; reads and any illegal op produce one pulse.
    // Faulted ops leave the previous read data in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_p1  <= 1'b0;
            rsp_err_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            rsp_vld_p1 <= bus.aux_ready & (~bus.aux_we | ~sel_legal);
            rsp_err_p1 <= bus.aux_ready & ~sel_legal;
            if (bus.aux_ready & ~bus.aux_we & sel_legal) begin
                rsp_data_p1 <= bus.read_data;
            end
        end
    end

    // ---- p1: sticky fault log (first fault wins) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (!err_flag_q && (gnt != GNT_NONE) && !sel_legal) begin
            err_flag_q <= 1'b1;
            err_addr_q <= sel_addr;
        end
    end

    // A response pulse still pending when reset rises is suppressed at once.
    assign bus.aux_rvalid = rsp_vld_p1 & ~reset;
    assign bus.aux_err    = rsp_err_p1 & ~reset;
    assign bus.aux_rdata  = rsp_data_p1;
    assign bus.err_flag   = err_flag_q;
    assign bus.err_addr   = err_addr_q;

endmodule
